s0_rs_enc: RTL and testbench

- Systematic RS(N_DATA+4, N_DATA) encoder over GF(2^8), primitive polynomial 0x11D, 2t=4 parity symbols.
- Generator roots are alpha^0..alpha^3: g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
- It is the transmit-side counterpart of the syndrome/KES decoder chain.
- Accepts a byte stream over valid/ready and emits codewords over valid/ready: N_DATA data symbols followed by 4 parity symbols.

---
 rtl/s0_rs_enc.sv | 141 ++++++++++++++
 tb/tb_s0_rs_enc.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s0_rs_enc.sv
// Systematic RS(N_DATA+4, N_DATA) encoder over GF(2^8) (poly 0x11D), 4 parity symbols, valid/ready in and out.
// Optional error injection for decoder verification is enabled with RS_ENC_ERRINJ_EN.
//
// state  | meaning
// S_DATA | accepting message symbols, updating the parity LFSR
// S_PAR  | draining the four parity symbols p3..p0 to the output register
module s0_rs_enc #(
  parameter int N_DATA = 251
) (
  input  logic       clk,
  input  logic       rst,
`ifdef RS_ENC_ERRINJ_EN
  input  logic       inj_en,
  input  logic [7:0] inj_pos,
  input  logic [7:0] inj_mask,
`endif
  input  logic       enc_in_valid,
  output logic       enc_in_ready,
  input  logic [7:0] enc_in_data,
  output logic       enc_out_valid,
  input  logic       enc_out_ready,
  output logic [7:0] enc_out_data,
  output logic       enc_out_sop,
  output logic       enc_out_eop
);

  localparam int CW = $clog2(N_DATA + 4);

  typedef enum logic {S_DATA, S_PAR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    pidx;
  logic [7:0]    r0, r1, r2, r3;
  logic          out_free, accept, last_data, par_load;
  logic [7:0]    fb, inj_x;
  logic [8:0]    idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign out_free     = !enc_out_valid || enc_out_ready;
  assign enc_in_ready = (state == S_DATA) && out_free;
  assign accept       = enc_in_valid && enc_in_ready;
  assign last_data    = (cnt == CW'(N_DATA - 1));
  assign par_load     = (state == S_PAR) && out_free;
  assign fb           = enc_in_data ^ r3;
  // Codeword position of the symbol that would load into the output register now.
  assign idx          = (state == S_DATA) ? 9'(cnt) : 9'(N_DATA) + 9'(pidx);

`ifdef RS_ENC_ERRINJ_EN
  logic       inj_en_q, first, eff_en;
  logic [7:0] inj_pos_q, inj_mask_q, eff_pos, eff_mask;

  // The first symbol uses the live injection inputs since they are only latched on that accept.
  assign first    = (state == S_DATA) && (cnt == '0);
  assign eff_en   = first ? inj_en   : inj_en_q;
  assign eff_pos  = first ? inj_pos  : inj_pos_q;
  assign eff_mask = first ? inj_mask : inj_mask_q;
  assign inj_x    = (eff_en && (9'(eff_pos) == idx)) ? eff_mask : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_en_q   <= 1'b0;
      inj_pos_q  <= 8'h00;
      inj_mask_q <= 8'h00;
    end else if (accept && first) begin
      inj_en_q   <= inj_en;
      inj_pos_q  <= inj_pos;
      inj_mask_q <= inj_mask;
    end
  end
`else
  assign inj_x = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_DATA;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA:  if (accept && last_data)      state_nxt = S_PAR;
      S_PAR:   if (par_load && pidx == 2'd3) state_nxt = S_DATA;
      default: state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      pidx          <= 2'd0;
      r0            <= 8'h00;
      r1            <= 8'h00;
      r2            <= 8'h00;
      r3            <= 8'h00;
      enc_out_valid <= 1'b0;
      enc_out_data  <= 8'h00;
      enc_out_sop   <= 1'b0;
      enc_out_eop   <= 1'b0;
    end else if (accept) begin
      r3            <= r2 ^ gf_mul(8'h0F, fb);
      r2            <= r1 ^ gf_mul(8'h36, fb);
      r1            <= r0 ^ gf_mul(8'h78, fb);
      r0            <= gf_mul(8'h40, fb);
      enc_out_data  <= enc_in_data ^ inj_x;
      enc_out_valid <= 1'b1;
      enc_out_sop   <= (cnt == '0);
      enc_out_eop   <= 1'b0;
      cnt           <= cnt + CW'(1);
      if (last_data) pidx <= 2'd0;
    end else if (par_load) begin
      enc_out_data  <= r3 ^ inj_x;
      r3            <= r2;
      r2            <= r1;
      r1            <= r0;
      r0            <= 8'h00;
      enc_out_valid <= 1'b1;
      enc_out_sop   <= 1'b0;
      enc_out_eop   <= (pidx == 2'd3);
      pidx          <= pidx + 2'd1;
      if (pidx == 2'd3) cnt <= '0;
    end else if (out_free) begin
      enc_out_valid <= 1'b0;
      enc_out_sop   <= 1'b0;
      enc_out_eop   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s0_rs_enc.sv
// Bench for s0_rs_enc (N_DATA=251): table-based GF(2^8) long-division model, per-cycle output compare and syndrome check.
// Define RS_ENC_ERRINJ_EN to also exercise the error injection ports.
module tb_s0_rs_enc;
  localparam int N = 251;
  localparam int L = N + 4;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_in_valid = 1'b0;
  logic       enc_in_ready;
  logic [7:0] enc_in_data = 8'h00;
  logic       enc_out_valid;
  logic       enc_out_ready = 1'b1;
  logic [7:0] enc_out_data;
  logic       enc_out_sop;
  logic       enc_out_eop;
`ifdef RS_ENC_ERRINJ_EN
  logic       inj_en = 1'b0;
  logic [7:0] inj_pos = 8'h00;
  logic [7:0] inj_mask = 8'h00;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 0;
  bit   rand_gaps = 0;
  bit   check_syn = 1;
  bit   prev_stall = 0;
  logic [9:0] held;

  logic [7:0] gexp [0:509];
  int         glog [0:255];
  logic [7:0] gen  [0:4];
  logic [7:0] msg  [0:N-1];
  logic [7:0] cw   [0:L-1];
  logic [7:0] rem  [0:L-1];
  exp_t       q[$];
  exp_t       e;
  logic [7:0] obuf[$];

  always #5 clk = ~clk;

  s0_rs_enc #(.N_DATA(N)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef RS_ENC_ERRINJ_EN
    .inj_en       (inj_en),
    .inj_pos      (inj_pos),
    .inj_mask     (inj_mask),
`endif
    .enc_in_valid (enc_in_valid),
    .enc_in_ready (enc_in_ready),
    .enc_in_data  (enc_in_data),
    .enc_out_valid(enc_out_valid),
    .enc_out_ready(enc_out_ready),
    .enc_out_data (enc_out_data),
    .enc_out_sop  (enc_out_sop),
    .enc_out_eop  (enc_out_eop)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[glog[a] + glog[b]];
  endfunction

  function automatic logic [7:0] syn(input int j);
    logic [7:0] s;
    s = 8'h00;
    foreach (obuf[k]) s = mul(s, gexp[j]) ^ obuf[k];
    return s;
  endfunction

  task automatic build_model();
    logic [8:0] x;
    x = 9'h001;
    glog[0] = 0;
    for (int i = 0; i < 255; i++) begin
      gexp[i]       = x[7:0];
      gexp[i + 255] = x[7:0];
      glog[x[7:0]]  = i;
      x = x << 1;
      if (x[8]) x = x ^ 9'h11D;
    end
    // g(x) = prod (x + alpha^r), r = 0..3, highest degree first
    gen[0] = 8'h01;
    for (int k = 1; k < 5; k++) gen[k] = 8'h00;
    for (int r = 0; r < 4; r++)
      for (int k = r + 1; k >= 1; k--) gen[k] = gen[k] ^ mul(gexp[r], gen[k-1]);
  endtask

  task automatic encode();
    logic [7:0] c;
    for (int k = 0; k < L; k++) rem[k] = (k < N) ? msg[k] : 8'h00;
    for (int i = 0; i < N; i++) begin
      c = rem[i];
      for (int j = 1; j < 5; j++) rem[i+j] = rem[i+j] ^ mul(c, gen[j]);
    end
    for (int k = 0; k < L; k++) cw[k] = (k < N) ? msg[k] : rem[k];
  endtask

  task automatic push_exp();
    for (int k = 0; k < L; k++) q.push_back('{cw[k], k == 0, k == L - 1});
  endtask

  task automatic send(input int rst_at);
    int waited;
    for (int i = 0; i < N; i++) begin
      if (i == rst_at) begin
        @(posedge clk); #1;
        enc_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("valid after mid rst", int'(enc_out_valid), 0);
        return;
      end
      if (rand_gaps && $urandom_range(3) == 0) begin
        @(posedge clk); #1;
        enc_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      enc_in_valid = 1'b1;
      enc_in_data  = msg[i];
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!enc_in_ready && waited < 500);
      if (!enc_in_ready) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready timeout: got 0 expected 1 at symbol %0d", i);
      end
    end
    @(posedge clk); #1;
    enc_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: got %0d symbols pending expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_msg();
    for (int k = 0; k < N; k++) msg[k] = 8'($urandom);
  endtask

  task automatic unit_msg(input logic [7:0] v);
    for (int k = 0; k < N; k++) msg[k] = 8'h00;
    msg[N-1] = v;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      enc_out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (prev_stall)
      check("hold under stall", int'({enc_out_valid, enc_out_data, enc_out_sop, enc_out_eop}), int'({1'b1, held}));
    if (enc_out_valid && enc_out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected output: got %0h expected none", enc_out_data);
      end else begin
        e = q.pop_front();
        check("out data", int'(enc_out_data), int'(e.d));
        check("out sop", int'(enc_out_sop), int'(e.sop));
        check("out eop", int'(enc_out_eop), int'(e.eop));
        obuf.push_back(enc_out_data);
        if (enc_out_eop) begin
          if (check_syn) begin
            check("codeword length", obuf.size(), L);
            for (int j = 0; j < 4; j++) check($sformatf("syndrome S%0d", j), int'(syn(j)), 0);
          end
          obuf.delete();
        end
      end
    end
    prev_stall = enc_out_valid && !enc_out_ready && !rst;
    held = {enc_out_data, enc_out_sop, enc_out_eop};
    if (rst) obuf.delete();
  end

  initial begin
    int lows;
    build_model();
    check("gen g3", int'(gen[1]), 'h0F);
    check("gen g2", int'(gen[2]), 'h36);
    check("gen g1", int'(gen[3]), 'h78);
    check("gen g0", int'(gen[4]), 'h40);

    repeat (3) @(posedge clk);
    #1;
    check("rst valid", int'(enc_out_valid), 0);
    check("rst data", int'(enc_out_data), 0);
    check("rst sop", int'(enc_out_sop), 0);
    check("rst eop", int'(enc_out_eop), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after rst", int'(enc_in_ready), 1);

    // message 0..0,01 : parity equals the low generator coefficients
    unit_msg(8'h01);
    encode();
    check("model p(01)", int'({cw[N], cw[N+1], cw[N+2], cw[N+3]}), 'h0F367840);
    push_exp();
    send(-1);
    drain();

    unit_msg(8'h02);
    encode();
    check("model p(02)", int'({cw[N], cw[N+1], cw[N+2], cw[N+3]}), 'h1E6CF080);
    push_exp();
    send(-1);
    drain();

    // all-zero message, downstream always ready: input side stalls exactly 4 cycles
    unit_msg(8'h00);
    encode();
    push_exp();
    send(-1);
    lows = 0;
    @(negedge clk);
    while (!enc_in_ready && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    check("parity ready-low cycles", lows, 4);
    drain();

    rand_ready = 1;
    rand_gaps  = 1;
    for (int n = 0; n < 3; n++) begin
      rand_msg();
      encode();
      push_exp();
      send(-1);
    end
    drain();

    // reset at symbol 100 of the first codeword, then a full codeword from clean state
    rand_msg();
    encode();
    push_exp();
    send(100);
    rand_msg();
    encode();
    push_exp();
    send(-1);
    drain();

`ifdef RS_ENC_ERRINJ_EN
    rand_ready = 0;
    rand_gaps  = 0;
    check_syn  = 0;
    unit_msg(8'h01);
    encode();
    cw[N+1] = cw[N+1] ^ 8'hFF;
    check("model inj p2", int'(cw[N+1]), 'hC9);
    push_exp();
    inj_en   = 1'b1;
    inj_pos  = 8'(N + 1);
    inj_mask = 8'hFF;
    send(-1);
    inj_en = 1'b0;
    drain();
    rand_msg();
    encode();
    cw[7] = cw[7] ^ 8'h5A;
    push_exp();
    inj_en   = 1'b1;
    inj_pos  = 8'd7;
    inj_mask = 8'h5A;
    send(-1);
    inj_en = 1'b0;
    drain();
    check_syn = 1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
